// File: rtl/dmul_pkg.sv
// Shared widths, window length and state encoding for the unary-multiplier sequencer.
package dmul_pkg;

   localparam int DATAWD_DEF = 8;
   localparam int WINDOW_DEF = 2**DATAWD_DEF - 1;
   localparam int CW         = 2*DATAWD_DEF;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_LOAD  = 3'd1;
   localparam logic [2:0] ST_RUN   = 3'd2;
   localparam logic [2:0] ST_DRAIN = 3'd3;
   localparam logic [2:0] ST_OUT   = 3'd4;

   typedef enum logic [2:0] {
      IDLE  = ST_IDLE,
      LOAD  = ST_LOAD,
      RUN   = ST_RUN,
      DRAIN = ST_DRAIN,
      OUT   = ST_OUT
   } dmul_state_t;

endpackage

// File: rtl/dmul_win_cnt.sv
// Stream-window counter: synchronous clear, count enable, flag when the count reaches TERM.
module dmul_win_cnt #(
   parameter int W    = 8,
   parameter int TERM = 254
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         en,
   output logic [W-1:0] cnt,
   output logic         term
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= '0;
      else if (clr)
         cnt <= '0;
      else if (en)
         cnt <= cnt + 1'b1;
   end

   assign term = (cnt == W'(TERM));

endmodule

// File: rtl/dmul_seq_ctrl.sv
// Sequencer around one rotating-LFSR unary multiplier: load, time one window, capture the count.
// A one-entry pending buffer accepts the next operand pair while the current one is in flight.
module dmul_seq_ctrl
   import dmul_pkg::*;
#(
   parameter int DATAWD = DATAWD_DEF,
   parameter int WINDOW = 2**DATAWD - 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATAWD-1:0]     in_a,
   input  logic [DATAWD-1:0]     in_b,
   input  logic [DATAWD-1:0]     cfg_seed_a,
   input  logic [DATAWD-1:0]     cfg_seed_b,
   input  logic [DATAWD-1:0]     cfg_seed_u,
   output logic [DATAWD-1:0]     mul_a,
   output logic [DATAWD-1:0]     mul_b,
   output logic                  mul_load_a,
   output logic                  mul_load_b,
   output logic [DATAWD-1:0]     mul_seed_a,
   output logic [DATAWD-1:0]     mul_seed_b,
   output logic [DATAWD-1:0]     mul_seed_u,
   input  logic [2*DATAWD-1:0]   mul_c,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [2*DATAWD-1:0]   out_c,
   output logic                  busy
);

   dmul_state_t         state, state_nxt;
   logic                pend_valid;
   logic [DATAWD-1:0]   pend_a, pend_b;
   logic [DATAWD-1:0]   act_a, act_b;
   logic [DATAWD-1:0]   cnt;
   logic                cnt_term;
   logic                in_hs;
   logic                move;

   assign in_ready = ~pend_valid;
   assign in_hs    = in_valid & in_ready;
   // Pending moves to active exactly on the edges that enter LOAD.
   assign move     = pend_valid & ((state == IDLE) | ((state == OUT) & out_ready));

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (pend_valid) state_nxt = LOAD;
         LOAD:    state_nxt = RUN;
         RUN:     if (cnt_term) state_nxt = DRAIN;
         DRAIN:   state_nxt = OUT;
         OUT:     if (out_ready) state_nxt = pend_valid ? LOAD : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         pend_valid <= 1'b0;
         pend_a     <= '0;
         pend_b     <= '0;
         act_a      <= '0;
         act_b      <= '0;
         out_c      <= '0;
      end else begin
         state      <= state_nxt;
         pend_valid <= in_hs | (pend_valid & ~move);
         if (in_hs) begin
            pend_a <= in_a;
            pend_b <= in_b;
         end
         if (move) begin
            act_a <= pend_a;
            act_b <= pend_b;
         end
         // mul_c has absorbed the last stream cycle by the time DRAIN is reached.
         if (state == DRAIN)
            out_c <= mul_c;
      end
   end

   dmul_win_cnt #(
      .W    (DATAWD),
      .TERM (WINDOW - 1)
   ) u_win_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (state == LOAD),
      .en    (state == RUN),
      .cnt   (cnt),
      .term  (cnt_term)
   );

   assign mul_a      = act_a;
   assign mul_b      = act_b;
   assign mul_load_a = (state == LOAD);
   assign mul_load_b = (state == LOAD);
   assign mul_seed_a = cfg_seed_a;
   assign mul_seed_b = cfg_seed_b;
   assign mul_seed_u = cfg_seed_u;
   assign out_valid  = (state == OUT);
   assign busy       = (state != IDLE) | pend_valid;

endmodule

// File: tb/tb_dmul_seq_ctrl.sv
// Bench for dmul_seq_ctrl with a behavioural LFSR multiplier and a result scoreboard.
module tb_dmul_seq_ctrl;
   import dmul_pkg::*;

   localparam int DW  = DATAWD_DEF;
   localparam int LAT = WINDOW_DEF + 3;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [DW-1:0] in_a = '0, in_b = '0;
   logic [DW-1:0] cfg_seed_a = 8'h01, cfg_seed_b = 8'h5A, cfg_seed_u = 8'hC3;
   logic [DW-1:0] mul_a, mul_b, mul_seed_a, mul_seed_b, mul_seed_u;
   logic          mul_load_a, mul_load_b;
   logic [CW-1:0] mul_c, out_c;
   logic          out_valid, busy;
   logic          out_ready = 1'b0;

   int nassert = 0;
   int nfail   = 0;
   int cyc     = 0;
   int load_cnt = 0;

   dmul_seq_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
      .cfg_seed_a(cfg_seed_a), .cfg_seed_b(cfg_seed_b), .cfg_seed_u(cfg_seed_u),
      .mul_a(mul_a), .mul_b(mul_b), .mul_load_a(mul_load_a), .mul_load_b(mul_load_b),
      .mul_seed_a(mul_seed_a), .mul_seed_b(mul_seed_b), .mul_seed_u(mul_seed_u),
      .mul_c(mul_c), .out_valid(out_valid), .out_ready(out_ready), .out_c(out_c),
      .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [DW-1:0] lfsr_step(input logic [DW-1:0] x);
      return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
   endfunction

   // Count of stream cycles where both operands beat their LFSR samples.
   function automatic logic [CW-1:0] golden(input logic [DW-1:0] a, b, sa, sb);
      logic [DW-1:0] x, y;
      int n;
      x = sa; y = sb; n = 0;
      for (int i = 0; i < WINDOW_DEF; i++) begin
         if (a > x && b > y) n++;
         x = lfsr_step(x);
         y = lfsr_step(y);
      end
      return CW'(n);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nassert++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Multiplier model: accumulates one compare per cycle after the load strobe.
   logic [DW-1:0] la = '0, lb = '0;
   logic [CW-1:0] mc = '0;
   assign mul_c = mc;
   always @(posedge clk) begin
      if (mul_load_a) begin
         la <= mul_seed_a;
         lb <= mul_seed_b;
         mc <= '0;
      end else begin
         if (mul_a > la && mul_b > lb) mc <= mc + 16'd1;
         la <= lfsr_step(la);
         lb <= lfsr_step(lb);
      end
   end

   logic [CW-1:0] exp_q[$];
   int            res_cyc[$];
   always @(posedge clk) begin
      if (rst_n && in_valid && in_ready)
         exp_q.push_back(golden(in_a, in_b, cfg_seed_a, cfg_seed_b));
      if (rst_n && out_valid && out_ready) begin
         res_cyc.push_back(cyc);
         check("result_expected_present", 32'(exp_q.size() != 0), 1);
         if (exp_q.size() != 0) check("result_value", 32'(out_c), 32'(exp_q.pop_front()));
      end
      if (rst_n && mul_load_a) load_cnt <= load_cnt + 1;
   end

   task automatic run_op(input logic [DW-1:0] a, b, input string tag);
      int e0, rise, na, nb;
      bit seen;
      rise = 0; na = 0; nb = 0; seen = 0;
      check({tag, "_in_ready"}, 32'(in_ready), 1);
      in_a = a; in_b = b; in_valid = 1'b1;
      tick();
      e0 = cyc;
      in_valid = 1'b0;
      for (int i = 0; i < LAT + 20 && !seen; i++) begin
         if (mul_load_a) na++;
         if (mul_load_b) nb++;
         tick();
         if (out_valid) begin seen = 1; rise = cyc; end
      end
      check({tag, "_latency"}, seen ? 32'(rise - e0) : 32'hFFFF_FFFF, LAT);
      check({tag, "_load_a_pulses"}, 32'(na), 1);
      check({tag, "_load_b_pulses"}, 32'(nb), 1);
      check({tag, "_out_c"}, 32'(out_c), 32'(golden(a, b, cfg_seed_a, cfg_seed_b)));
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check({tag, "_out_valid_cleared"}, 32'(out_valid), 0);
      check({tag, "_idle_not_busy"}, 32'(busy), 0);
   endtask

   initial begin
      #200_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [DW-1:0] pa[3], pb[3];
      logic [CW-1:0] held;
      int k, guard, loads0;
      bit hs, seen;

      // Reset state
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", 32'(in_ready), 1);
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_load_a", 32'(mul_load_a), 0);
      check("rst_load_b", 32'(mul_load_b), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_out_c", 32'(out_c), 0);
      check("rst_mul_a", 32'(mul_a), 0);
      check("rst_mul_b", 32'(mul_b), 0);
      check("seed_u_copy", 32'(mul_seed_u), 32'(cfg_seed_u));
      rst_n = 1'b1;
      tick();

      // Single ops: nominal and zero operand
      run_op(8'd128, 8'd128, "single_128");
      run_op(8'd0, 8'd255, "zero_a");
      check("zero_a_out_c_zero", 32'(out_c), 0);

      // Random ops with random nonzero seeds
      for (int r = 0; r < 4; r++) begin
         cfg_seed_a = 8'($urandom_range(1, 255));
         cfg_seed_b = 8'($urandom_range(1, 255));
         cfg_seed_u = 8'($urandom_range(1, 255));
         run_op(8'($urandom), 8'($urandom), "rand_op");
         check("rand_seed_a_copy", 32'(mul_seed_a), 32'(cfg_seed_a));
      end

      // Backpressure with pending full
      in_a = 8'($urandom); in_b = 8'($urandom); in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (10) tick();
      in_a = 8'($urandom); in_b = 8'($urandom); in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      check("bp_pending_full", 32'(in_ready), 0);
      seen = 0;
      for (int i = 0; i < LAT && !seen; i++) begin
         tick();
         seen = out_valid;
      end
      check("bp_reached_out", 32'(seen), 1);
      held = out_c;
      in_a = 8'($urandom); in_b = 8'($urandom); in_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         check("bp_out_valid_held", 32'(out_valid), 1);
         check("bp_out_c_stable", 32'(out_c), 32'(held));
         check("bp_no_load", 32'(mul_load_a), 0);
         check("bp_in_ready_low", 32'(in_ready), 0);
         tick();
      end
      out_ready = 1'b1;
      tick();
      check("bp_load_after_out", 32'(mul_load_a), 1);
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 3 * LAT && exp_q.size() != 0; i++) tick();
      tick();
      check("bp_drained", 32'(exp_q.size()), 0);
      check("bp_idle", 32'(busy), 0);

      // Back-to-back, out_ready held high
      res_cyc.delete();
      loads0 = load_cnt;
      for (int i = 0; i < 3; i++) begin pa[i] = 8'($urandom); pb[i] = 8'($urandom); end
      k = 0; guard = 0;
      in_a = pa[0]; in_b = pb[0]; in_valid = 1'b1;
      while (k < 3 && guard < 2000) begin
         hs = in_ready;
         tick();
         guard++;
         if (hs) begin
            k++;
            if (k == 2) check("b2b_in_ready_after_2nd", 32'(in_ready), 0);
            if (k < 3) begin in_a = pa[k]; in_b = pb[k]; end
            else in_valid = 1'b0;
         end
      end
      check("b2b_all_accepted", 32'(k), 3);
      for (int i = 0; i < 4 * LAT && res_cyc.size() < 3; i++) tick();
      check("b2b_results", 32'(res_cyc.size()), 3);
      if (res_cyc.size() == 3) begin
         check("b2b_spacing_1", 32'(res_cyc[1] - res_cyc[0]), LAT);
         check("b2b_spacing_2", 32'(res_cyc[2] - res_cyc[1]), LAT);
      end
      tick();
      check("b2b_loads", 32'(load_cnt - loads0), 3);
      out_ready = 1'b0;

      // Reset mid-RUN
      in_a = 8'd200; in_b = 8'd100; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (100) tick();
      check("mid_busy", 32'(busy), 1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_in_ready", 32'(in_ready), 1);
      check("arst_out_valid", 32'(out_valid), 0);
      check("arst_busy", 32'(busy), 0);
      check("arst_load_a", 32'(mul_load_a), 0);
      check("arst_mul_a", 32'(mul_a), 0);
      check("arst_mul_b", 32'(mul_b), 0);
      check("arst_out_c", 32'(out_c), 0);
      exp_q.delete();
      tick();
      rst_n = 1'b1;
      tick();
      run_op(8'd64, 8'd64, "post_rst");

      check("scoreboard_empty", 32'(exp_q.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
      $finish;
   end

endmodule
